ahb_sram: RTL and testbench

//  AHB-Lite zero-wait-state SRAM slave that consumes the Cortex-M0 integration master port (cm0_h* nets in soc).

---
 rtl/ahb_sram.sv | 131 +++++++++++++
 tb/tb_ahb_sram.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram.sv
// AHB-Lite zero-wait-state SRAM slave with byte/halfword/word lanes, write->read
// forwarding and a two-cycle ERROR response for illegal size or misaligned transfers.
module ahb_sram #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [1:0] {
    ST_OKAY = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } state_t;

  logic [31:0]   mem [DEPTH];
  logic          accept;
  logic          legal;
  logic [3:0]    lane_mask;
  logic [IW-1:0] addr_idx;
  logic [31:0]   rd_word;

  logic          wr_pend;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_mask;

  state_t        state;
  state_t        state_nxt;

  // Address bits above the decoded window alias; HTRANS[0] only separates NONSEQ from SEQ.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign addr_idx = HADDR[ADDR_WIDTH-1:2];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    legal     = 1'b0;
    lane_mask = 4'b0000;
    case (HSIZE)
      3'b000: begin
        legal     = 1'b1;
        lane_mask = 4'b0001 << HADDR[1:0];
      end
      3'b001: begin
        legal     = ~HADDR[0];
        lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        legal     = (HADDR[1:0] == 2'b00);
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  // A read accepted on the edge that commits a write to the same word sees the new lanes.
  always_comb begin
    rd_word = mem[addr_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_pend && (wr_idx == addr_idx) && wr_mask[b]) begin
        rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      wr_mask <= '0;
      HRDATA  <= '0;
    end else begin
      wr_pend <= accept & legal & HWRITE;
      if (accept && legal && HWRITE) begin
        wr_idx  <= addr_idx;
        wr_mask <= lane_mask;
      end
      if (accept && legal && !HWRITE) begin
        HRDATA <= rd_word;
      end
    end
  end

  // NOTE: the array has no reset; clearing wr_pend on reset is what drops an in-flight write.
  always_ff @(posedge HCLK) begin
    if (wr_pend) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_OKAY;
    end else begin
      state <= state_nxt;
    end
  end

  // ERR2 drives HREADYOUT high, so a transfer presented then is accepted and judged normally.
  always_comb begin
    state_nxt = ST_OKAY;
    case (state)
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = (accept && !legal) ? ST_ERR1 : ST_OKAY;
    endcase
  end

  assign HREADYOUT = (state != ST_ERR1);
  assign HRESP     = (state != ST_OKAY);

endmodule

// File: tb/tb_ahb_sram.sv
// Self-checking bench for ahb_sram: directed scenarios plus random pipelined traffic,
// with expected read data queued at address phase and compared in the data phase.
module tb_ahb_sram;

  localparam int AW = 14;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HALF  = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] pend_wdata;
  logic [31:0] s_rdata;
  logic        s_rdy;
  logic        s_resp;
  logic [31:0] model [16];

  ahb_sram #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  // Sole slave on the bus, so the bus-wide ready is its own ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // One bus cycle: drive an address phase plus the data of the previous write,
  // then sample the data-phase response of this transfer on the falling edge.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HWDATA = pend_wdata;
    @(posedge HCLK);
    pend_wdata = wdata;
    @(negedge HCLK);
    s_rdata = HRDATA;
    s_rdy   = HREADYOUT;
    s_resp  = HRESP;
  endtask

  task automatic idle();
    step(1'b0, T_IDLE, 1'b0, 32'h0, SZ_WORD, 32'h0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
    step(1'b1, T_NONSEQ, 1'b1, addr, size, d);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] expv);
    exp_q.push_back(expv);
    step(1'b1, T_NONSEQ, 1'b0, addr, size, 32'h0);
  endtask

  function automatic void model_write(input int idx, input logic [1:0] off,
                                      input logic [2:0] size, input logic [31:0] d);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic test_reset();
    HRESETn    = 1'b0;
    HSEL       = 1'b0;
    HADDR      = 32'h0;
    HTRANS     = T_IDLE;
    HWRITE     = 1'b0;
    HSIZE      = SZ_WORD;
    HWDATA     = 32'h0;
    pend_wdata = 32'h0;
    repeat (2) @(negedge HCLK);
    checks++;
    if (HREADYOUT !== 1'b1) begin
      failures++;
      $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT);
    end
    checks++;
    if (HRESP !== 1'b0) begin
      failures++;
      $display("FAIL reset_hresp: got %b want 0", HRESP);
    end
    checks++;
    if (HRDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_hrdata: got %h want 00000000", HRDATA);
    end
    HRESETn = 1'b1;
    idle();
  endtask

  task automatic test_word_rw();
    do_write(32'h10, SZ_WORD, 32'hDEADBEEF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b10) begin
      failures++;
      $display("FAIL word_write_resp: rdy/resp=%b%b want 10", s_rdy, s_resp);
    end
    idle();
    do_read(32'h10, SZ_WORD, 32'hDEADBEEF);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v || s_rdy !== 1'b1 || s_resp !== 1'b0) begin
      failures++;
      $display("FAIL word_read: got %h rdy=%b resp=%b want %h rdy=1 resp=0", s_rdata, s_rdy, s_resp, exp_v);
    end
    idle();
  endtask

  task automatic test_subword();
    do_write(32'h10, SZ_WORD, 32'h0);
    do_write(32'h13, SZ_BYTE, 32'hA500_0000);
    do_write(32'h10, SZ_HALF, 32'h0000_1234);
    idle();
    do_read(32'h10, SZ_WORD, 32'hA500_1234);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v || s_resp !== 1'b0) begin
      failures++;
      $display("FAIL subword_merge: got %h resp=%b want %h resp=0", s_rdata, s_resp, exp_v);
    end
    // Byte read at an odd address still returns the whole word.
    do_read(32'h11, SZ_BYTE, 32'hA500_1234);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL byte_read_full_word: got %h want %h", s_rdata, exp_v);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_write(32'h20, SZ_WORD, 32'h1122_3344);
    do_write(32'h21, SZ_BYTE, 32'h0000_AB00);
    do_read(32'h20, SZ_WORD, 32'h1122_AB44);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v || s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL forward_byte: got %h rdy=%b want %h rdy=1", s_rdata, s_rdy, exp_v);
    end
    do_write(32'h22, SZ_HALF, 32'hBEEF_0000);
    do_read(32'h20, SZ_WORD, 32'hBEEF_AB44);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL forward_half: got %h want %h", s_rdata, exp_v);
    end
    idle();
  endtask

  task automatic test_error();
    do_write(32'h0, SZ_WORD, 32'hCAFE_F00D);
    idle();
    step(1'b1, T_NONSEQ, 1'b0, 32'h2, SZ_WORD, 32'h0);
    checks++;
    if ({s_rdy, s_resp} !== 2'b01) begin
      failures++;
      $display("FAIL err_misaligned_word_c1: rdy/resp=%b%b want 01", s_rdy, s_resp);
    end
    idle();
    checks++;
    if ({s_rdy, s_resp} !== 2'b11) begin
      failures++;
      $display("FAIL err_misaligned_word_c2: rdy/resp=%b%b want 11", s_rdy, s_resp);
    end
    idle();
    checks++;
    if ({s_rdy, s_resp} !== 2'b10) begin
      failures++;
      $display("FAIL err_return_okay: rdy/resp=%b%b want 10", s_rdy, s_resp);
    end
    step(1'b1, T_NONSEQ, 1'b1, 32'h0, 3'b011, 32'hFFFF_FFFF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b01) begin
      failures++;
      $display("FAIL err_size3_c1: rdy/resp=%b%b want 01", s_rdy, s_resp);
    end
    idle();
    checks++;
    if ({s_rdy, s_resp} !== 2'b11) begin
      failures++;
      $display("FAIL err_size3_c2: rdy/resp=%b%b want 11", s_rdy, s_resp);
    end
    // Illegal transfer presented during ERR2 restarts the error sequence.
    step(1'b1, T_NONSEQ, 1'b1, 32'h1, SZ_HALF, 32'hFFFF_FFFF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b01) begin
      failures++;
      $display("FAIL err_half_in_err2: rdy/resp=%b%b want 01", s_rdy, s_resp);
    end
    idle();
    // Legal read presented during ERR2 is served normally.
    do_read(32'h0, SZ_WORD, 32'hCAFE_F00D);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v || {s_rdy, s_resp} !== 2'b10) begin
      failures++;
      $display("FAIL err_mem_unchanged: got %h rdy/resp=%b%b want %h 10", s_rdata, s_rdy, s_resp, exp_v);
    end
    idle();
  endtask

  task automatic test_reset_midop();
    do_write(32'h0, SZ_WORD, 32'h0BAD_BEEF);
    idle();
    do_read(32'h0, SZ_WORD, 32'h0BAD_BEEF);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL pre_reset_read: got %h want %h", s_rdata, exp_v);
    end
    do_write(32'h0, SZ_WORD, 32'hFFFF_0000);
    HSEL       = 1'b0;
    HTRANS     = T_IDLE;
    HWDATA     = pend_wdata;
    pend_wdata = 32'h0;
    #1 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HREADYOUT, HRESP} !== 2'b10 || HRDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_async_outputs: rdy/resp=%b%b HRDATA=%h want 10 00000000", HREADYOUT, HRESP, HRDATA);
    end
    #1 HRESETn = 1'b1;
    idle();
    do_read(32'h0, SZ_WORD, 32'h0BAD_BEEF);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL reset_drops_write: got %h want %h", s_rdata, exp_v);
    end
    step(1'b1, T_NONSEQ, 1'b1, 32'h1, SZ_HALF, 32'h0);
    HSEL   = 1'b0;
    HTRANS = T_IDLE;
    #1 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HREADYOUT, HRESP} !== 2'b10) begin
      failures++;
      $display("FAIL reset_in_err1: rdy/resp=%b%b want 10", HREADYOUT, HRESP);
    end
    #1 HRESETn = 1'b1;
    idle();
    checks++;
    if ({s_rdy, s_resp} !== 2'b10) begin
      failures++;
      $display("FAIL fsm_after_reset: rdy/resp=%b%b want 10", s_rdy, s_resp);
    end
  endtask

  task automatic test_alias_idle();
    do_write(32'h1 << AW, SZ_WORD, 32'h0000_0055);
    idle();
    do_read(32'h0, SZ_WORD, 32'h0000_0055);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL alias_read: got %h want %h", s_rdata, exp_v);
    end
    do_write(32'h3FFC, SZ_WORD, 32'h7777_7777);
    do_read(32'h3FFC, SZ_WORD, 32'h7777_7777);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL top_word: got %h want %h", s_rdata, exp_v);
    end
    do_read(32'h4000, SZ_WORD, 32'h0000_0055);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL top_wrap_word0: got %h want %h", s_rdata, exp_v);
    end
    step(1'b1, T_IDLE, 1'b1, 32'h0, SZ_WORD, 32'hFFFF_FFFF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b10 || s_rdata !== 32'h0000_0055) begin
      failures++;
      $display("FAIL idle_okay: rdy/resp=%b%b HRDATA=%h want 10 00000055", s_rdy, s_resp, s_rdata);
    end
    step(1'b1, T_BUSY, 1'b1, 32'h0, SZ_WORD, 32'hFFFF_FFFF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b10 || s_rdata !== 32'h0000_0055) begin
      failures++;
      $display("FAIL busy_okay: rdy/resp=%b%b HRDATA=%h want 10 00000055", s_rdy, s_resp, s_rdata);
    end
    step(1'b0, T_NONSEQ, 1'b1, 32'h0, SZ_WORD, 32'hFFFF_FFFF);
    checks++;
    if ({s_rdy, s_resp} !== 2'b10) begin
      failures++;
      $display("FAIL unselected_okay: rdy/resp=%b%b want 10", s_rdy, s_resp);
    end
    idle();
    do_read(32'h0, SZ_WORD, 32'h0000_0055);
    checks++;
    exp_v = exp_q.pop_front();
    if (s_rdata !== exp_v) begin
      failures++;
      $display("FAIL no_access_when_idle: got %h want %h", s_rdata, exp_v);
    end
    idle();
  endtask

  task automatic test_random_traffic();
    logic [31:0] base;
    logic [31:0] d;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  off;
    logic [1:0]  trans;
    int          idx;
    base = 32'h100;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model[i] = d;
      do_write(base + 32'(4 * i), SZ_WORD, d);
    end
    for (int n = 0; n < 120; n++) begin
      idx   = int'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 2));
      off   = (size == SZ_BYTE) ? 2'($urandom_range(0, 3)) :
              (size == SZ_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      addr  = base + 32'(4 * idx) + 32'(off);
      trans = ($urandom_range(0, 1) == 1) ? T_SEQ : T_NONSEQ;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        model_write(idx, off, size, d);
        step(1'b1, trans, 1'b1, addr, size, d);
        checks++;
        if ({s_rdy, s_resp} !== 2'b10) begin
          failures++;
          $display("FAIL rand_write_resp: addr=%h rdy/resp=%b%b want 10", addr, s_rdy, s_resp);
        end
      end else begin
        exp_q.push_back(model[idx]);
        step(1'b1, trans, 1'b0, addr, size, 32'h0);
        checks++;
        exp_v = exp_q.pop_front();
        if (s_rdata !== exp_v || {s_rdy, s_resp} !== 2'b10) begin
          failures++;
          $display("FAIL rand_read: addr=%h got %h rdy/resp=%b%b want %h 10", addr, s_rdata, s_rdy, s_resp, exp_v);
        end
      end
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_word_rw();
    test_subword();
    test_back_to_back();
    test_error();
    test_reset_midop();
    test_alias_idle();
    test_random_traffic();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
